// File: rtl/i2s_transmitter_if.sv
// Sample and I2S pin bundle between the NCO/DAC side and the transmitter.
// The transmitter owns the pins and the strobe; the NCO supplies the sample.
interface i2s_transmitter_if;
    logic signed [15:0] sample_in;
    logic               sample_clk_en;
    logic               bclk;
    logic               lrclk;
    logic               sdata;

    modport master (
        input  sample_in,
        output sample_clk_en,
        output bclk,
        output lrclk,
        output sdata
    );

    modport slave (
        output sample_in,
        input  sample_clk_en,
        input  bclk,
        input  lrclk,
        input  sdata
    );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: BCLK/LRCLK generation, 48 kHz frame strobe and
// MSB-first mono serialisation of a sample latched once per frame.
module i2s_transmitter #(
    parameter int BCLK_DIV = 2
) (
    input  logic               master_clk,
    input  logic               rst,
    i2s_transmitter_if.master  bus
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic signed [15:0] shadow_q, shadow_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               strobe_q, strobe_d;
    logic               fall;
    logic [4:0]         slot;

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        bclk_d    = bclk_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        fall      = 1'b0;
        slot      = 5'd0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            fall      = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
            slot      = bit_cnt_d[4:0];
            // Slot 0 is the one-BCLK I2S delay; slots 17..31 are zero pad.
            if (slot >= 5'd1 && slot <= 5'd16) begin
                sdata_d = shadow_q[4'(5'd16 - slot)];
            end else begin
                sdata_d = 1'b0;
            end
            if (bit_cnt_q == 6'd63) begin
                strobe_d = 1'b1;
                shadow_d = bus.sample_in;
            end
        end
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= 6'd63;
            shadow_q  <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b1;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.sample_clk_en = strobe_q;
    assign bus.bclk          = bclk_q;
    assign bus.lrclk         = lrclk_q;
    assign bus.sdata         = sdata_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at BCLK_DIV = 2 and BCLK_DIV = 1.
module tb_i2s_transmitter;
    logic clk = 1'b0;
    logic rst_n2 = 1'b0;
    logic rst_n1 = 1'b0;
    int   errors = 0;
    int   checks = 0;

    i2s_transmitter_if if2 ();
    i2s_transmitter_if if1 ();

    i2s_transmitter #(.BCLK_DIV(2)) dut2 (
        .master_clk (clk),
        .rst        (rst_n2),
        .bus        (if2.master)
    );

    i2s_transmitter #(.BCLK_DIV(1)) dut1 (
        .master_clk (clk),
        .rst        (rst_n1),
        .bus        (if1.master)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    function automatic logic get_stb(input bit sel);
        return sel ? if1.sample_clk_en : if2.sample_clk_en;
    endfunction

    function automatic logic get_bclk(input bit sel);
        return sel ? if1.bclk : if2.bclk;
    endfunction

    // Edges from now until sample_clk_en is seen high (#1 after an edge).
    task automatic wait_strobe(input bit sel, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!get_stb(sel) && cyc < 400);
        if (!get_stb(sel)) begin
            errors++;
            checks++;
            $display("FAIL strobe_timeout sel=%0d waited=%0d", sel, cyc);
        end
    endtask

    // Record sdata/lrclk at 64 bclk rising edges; bit 63-i holds slot i.
    task automatic capture_slots(input bit sel, output logic [63:0] sd,
                                 output logic [63:0] lr);
        int n;
        int guard;
        logic prev;
        logic cur;
        sd = '0;
        lr = '0;
        n = 0;
        guard = 0;
        prev = get_bclk(sel);
        while (n < 64 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
            cur = get_bclk(sel);
            if (cur && !prev) begin
                sd[63-n] = sel ? if1.sdata : if2.sdata;
                lr[63-n] = sel ? if1.lrclk : if2.lrclk;
                n++;
            end
            prev = cur;
        end
        if (n < 64) begin
            errors++;
            checks++;
            $display("FAIL capture_timeout sel=%0d slots=%0d", sel, n);
        end
    endtask

    task automatic test_reset();
        int n;
        int rise;
        int p;
        if2.sample_in = 16'h0000;
        repeat (10) @(posedge clk);
        #1;
        checks += 4;
        if (if2.bclk !== 1'b0) begin
            errors++; $display("FAIL rst_bclk got=%b exp=0", if2.bclk);
        end
        if (if2.lrclk !== 1'b1) begin
            errors++; $display("FAIL rst_lrclk got=%b exp=1", if2.lrclk);
        end
        if (if2.sdata !== 1'b0) begin
            errors++; $display("FAIL rst_sdata got=%b exp=0", if2.sdata);
        end
        if (if2.sample_clk_en !== 1'b0) begin
            errors++; $display("FAIL rst_stb got=%b exp=0", if2.sample_clk_en);
        end
        @(negedge clk);
        rst_n2 = 1'b1;
        n = 0;
        rise = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (if2.bclk === 1'b1 && rise == 0) rise = n;
        end while (if2.sample_clk_en !== 1'b1 && n < 20);
        checks += 4;
        if (rise != 2) begin
            errors++; $display("FAIL first_bclk_rise got=%0d exp=2", rise);
        end
        if (n != 4) begin
            errors++; $display("FAIL first_strobe got=%0d exp=4", n);
        end
        if (if2.lrclk !== 1'b0) begin
            errors++; $display("FAIL slot0_lrclk got=%b exp=0", if2.lrclk);
        end
        if (if2.sdata !== 1'b0) begin
            errors++; $display("FAIL slot0_sdata got=%b exp=0", if2.sdata);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (if2.sample_clk_en !== 1'b0) begin
                errors++; $display("FAIL strobe_width frame=%0d got=1 exp=0", i);
            end
            wait_strobe(1'b0, p);
            checks++;
            if (p + 1 != 256) begin
                errors++; $display("FAIL strobe_period frame=%0d got=%0d exp=256", i, p + 1);
            end
        end
    endtask

    task automatic test_serial_a5c3();
        logic [63:0] sd;
        logic [63:0] lr;
        if2.sample_in = 16'hA5C3;
        wait_strobe(1'b0, sd[31:0]);
        capture_slots(1'b0, sd, lr);
        checks += 2;
        if (sd !== {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'hA5C3, 15'h0}) begin
            errors++; $display("FAIL a5c3_sdata got=%h", sd);
        end
        if (lr !== LR_EXP) begin
            errors++; $display("FAIL a5c3_lrclk got=%h exp=%h", lr, LR_EXP);
        end
    endtask

    task automatic test_latch_isolation();
        logic [63:0] sd;
        logic [63:0] lr;
        int p;
        if2.sample_in = 16'h1234;
        wait_strobe(1'b0, p);
        if2.sample_in = 16'hFFFF;
        capture_slots(1'b0, sd, lr);
        checks++;
        if (sd !== {1'b0, 16'h1234, 15'h0, 1'b0, 16'h1234, 15'h0}) begin
            errors++; $display("FAIL latch_1234 got=%h", sd);
        end
        wait_strobe(1'b0, p);
        capture_slots(1'b0, sd, lr);
        checks++;
        if (sd !== {1'b0, 16'hFFFF, 15'h0, 1'b0, 16'hFFFF, 15'h0}) begin
            errors++; $display("FAIL latch_ffff got=%h", sd);
        end
    endtask

    task automatic test_extremes();
        logic [63:0] sd;
        logic [63:0] lr;
        int p;
        if2.sample_in = 16'h8000;
        wait_strobe(1'b0, p);
        capture_slots(1'b0, sd, lr);
        checks++;
        if (sd !== 64'h4000_0000_4000_0000) begin
            errors++; $display("FAIL ext_8000 got=%h exp=4000000040000000", sd);
        end
        if2.sample_in = 16'h7FFF;
        wait_strobe(1'b0, p);
        capture_slots(1'b0, sd, lr);
        checks++;
        if (sd !== 64'h3FFF_8000_3FFF_8000) begin
            errors++; $display("FAIL ext_7fff got=%h exp=3fff80003fff8000", sd);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int p;
        int guard;
        logic prev;
        if2.sample_in = 16'hFFFF;
        wait_strobe(1'b0, p);
        n = 0;
        guard = 0;
        prev = if2.bclk;
        while (n < 21 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            if (if2.bclk && !prev) n++;
            prev = if2.bclk;
        end
        checks += 2;
        if (n != 21) begin
            errors++; $display("FAIL mid_seek_timeout slots=%0d exp=21", n);
        end
        if (if2.bclk !== 1'b1 || if2.lrclk !== 1'b0) begin
            errors++; $display("FAIL mid_pre bclk=%b lrclk=%b exp=1,0", if2.bclk, if2.lrclk);
        end
        @(negedge clk);
        rst_n2 = 1'b0;
        #1;
        checks += 5;
        if (if2.bclk !== 1'b0) begin
            errors++; $display("FAIL mid_bclk got=%b exp=0", if2.bclk);
        end
        if (if2.lrclk !== 1'b1) begin
            errors++; $display("FAIL mid_lrclk got=%b exp=1", if2.lrclk);
        end
        if (if2.sdata !== 1'b0) begin
            errors++; $display("FAIL mid_sdata got=%b exp=0", if2.sdata);
        end
        if (if2.sample_clk_en !== 1'b0) begin
            errors++; $display("FAIL mid_stb got=%b exp=0", if2.sample_clk_en);
        end
        if (dut2.shadow_q !== 16'h0000) begin
            errors++; $display("FAIL mid_shadow got=%h exp=0000", dut2.shadow_q);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n2 = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (if2.sample_clk_en !== 1'b1 && n < 20);
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL mid_first_strobe got=%0d exp=4", n);
        end
        @(posedge clk);
        #1;
        wait_strobe(1'b0, p);
        checks++;
        if (p + 1 != 256) begin
            errors++; $display("FAIL mid_period got=%0d exp=256", p + 1);
        end
    endtask

    task automatic test_div1();
        logic [63:0] sd;
        logic [63:0] lr;
        int n;
        int p;
        if1.sample_in = 16'hA5C3;
        checks++;
        if (if1.bclk !== 1'b0 || if1.lrclk !== 1'b1) begin
            errors++; $display("FAIL d1_rst bclk=%b lrclk=%b exp=0,1", if1.bclk, if1.lrclk);
        end
        @(negedge clk);
        rst_n1 = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (if1.sample_clk_en !== 1'b1 && n < 20);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL d1_first_strobe got=%0d exp=2", n);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (if1.sample_clk_en !== 1'b0) begin
                errors++; $display("FAIL d1_width frame=%0d got=1 exp=0", i);
            end
            if (if1.bclk !== 1'b1) begin
                errors++; $display("FAIL d1_toggle frame=%0d got=%b exp=1", i, if1.bclk);
            end
            wait_strobe(1'b1, p);
            checks++;
            if (p + 1 != 128) begin
                errors++; $display("FAIL d1_period frame=%0d got=%0d exp=128", i, p + 1);
            end
        end
        capture_slots(1'b1, sd, lr);
        checks += 2;
        if (sd !== {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'hA5C3, 15'h0}) begin
            errors++; $display("FAIL d1_sdata got=%h", sd);
        end
        if (lr !== LR_EXP) begin
            errors++; $display("FAIL d1_lrclk got=%h exp=%h", lr, LR_EXP);
        end
    endtask

    initial begin
        if1.sample_in = 16'h0000;
        if2.sample_in = 16'h0000;
        test_reset();
        test_serial_a5c3();
        test_latch_isolation();
        test_extremes();
        test_reset_mid_frame();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
